// File: rtl/dmem_portb_arbiter.sv
// Round-robin arbiter sharing dmem port B between the debug bridge (0) and the DMA engine (1),
// with burst locking bounded by MAX_LOCK; 0-cycle request path, 1-cycle response, no response backpressure.
module dmem_portb_arbiter #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_LOCK   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  output logic [1:0]              req_ready,
  input  logic [1:0]              req_we,
  input  logic [1:0]              req_lock,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb0,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb1,
  input  logic [ADDR_WIDTH-1:0]   req_addr0,
  input  logic [ADDR_WIDTH-1:0]   req_addr1,
  input  logic [DATA_WIDTH-1:0]   req_wdata0,
  input  logic [DATA_WIDTH-1:0]   req_wdata1,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    en_b,
  output logic                    we_b,
  output logic [DATA_WIDTH/8-1:0] wstrb_b,
  output logic [ADDR_WIDTH-1:0]   addr_b,
  output logic [DATA_WIDTH-1:0]   din_b,
  input  logic [DATA_WIDTH-1:0]   dout_b
);

  localparam int CW = $clog2(MAX_LOCK + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_LOCK);

  typedef enum logic [1:0] {ARB, LOCK0, LOCK1} state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            rsp_pend_q, rsp_pend_d;
  logic            rsp_owner_q, rsp_owner_d;
  logic            rsp_is_rd_q, rsp_is_rd_d;

  logic                    gnt_vld;
  logic                    gnt_id;
  logic                    forced;
  logic                    sel_we;
  logic                    sel_lock;
  logic [DATA_WIDTH/8-1:0] sel_strb;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = 1'b0;
    forced  = 1'b0;
    unique case (state_q)
      ARB: begin
        if (&req_valid) begin
          gnt_vld = 1'b1;
          gnt_id  = ~last_grant_q;
        end else if (req_valid[0]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end else if (req_valid[1]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      // A saturated lock owes the other requester one beat; otherwise only the owner may go.
      LOCK0: begin
        if (lock_cnt_q == MAX_CNT && req_valid[1]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
          forced  = 1'b1;
        end else if (req_valid[0]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
        end
      end
      LOCK1: begin
        if (lock_cnt_q == MAX_CNT && req_valid[0]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b0;
          forced  = 1'b1;
        end else if (req_valid[1]) begin
          gnt_vld = 1'b1;
          gnt_id  = 1'b1;
        end
      end
      default: ;
    endcase
    if (rst) gnt_vld = 1'b0;

    sel_we    = gnt_id ? req_we[1]   : req_we[0];
    sel_lock  = gnt_id ? req_lock[1] : req_lock[0];
    sel_strb  = gnt_id ? req_wstrb1  : req_wstrb0;
    sel_addr  = gnt_id ? req_addr1   : req_addr0;
    sel_wdata = gnt_id ? req_wdata1  : req_wdata0;

    req_ready = gnt_vld ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
    en_b      = gnt_vld;
    we_b      = gnt_vld & sel_we;
    wstrb_b   = (gnt_vld && sel_we) ? sel_strb : '0;
    addr_b    = gnt_vld ? sel_addr  : '0;
    din_b     = gnt_vld ? sel_wdata : '0;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    lock_cnt_d   = lock_cnt_q;
    rsp_pend_d   = gnt_vld;
    rsp_owner_d  = gnt_id;
    rsp_is_rd_d  = gnt_vld & ~sel_we;

    if (gnt_vld && forced) begin
      lock_cnt_d = '0;
    end else if (gnt_vld) begin
      last_grant_d = gnt_id;
      if (sel_lock) begin
        state_d = gnt_id ? LOCK1 : LOCK0;
        if (lock_cnt_q != MAX_CNT) lock_cnt_d = lock_cnt_q + CW'(1);
      end else begin
        state_d    = ARB;
        lock_cnt_d = '0;
      end
    end

    rsp_valid = (rsp_pend_q && !rst) ? (rsp_owner_q ? 2'b10 : 2'b01) : 2'b00;
    rsp_rdata = (rsp_pend_q && rsp_is_rd_q && !rst) ? dout_b : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      lock_cnt_q   <= '0;
      rsp_pend_q   <= 1'b0;
      rsp_owner_q  <= 1'b0;
      rsp_is_rd_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_owner_q  <= rsp_owner_d;
      rsp_is_rd_q  <= rsp_is_rd_d;
    end
  end

endmodule

// File: tb/tb_dmem_portb_arbiter.sv
// Directed bench for dmem_portb_arbiter with a behavioural port-B memory and a response scoreboard.
module tb_dmem_portb_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [1:0]    req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [SW-1:0] req_wstrb0, req_wstrb1, wstrb_b;
  logic [AW-1:0] req_addr0, req_addr1, addr_b;
  logic [DW-1:0] req_wdata0, req_wdata1, rsp_rdata, din_b, dout_b;
  logic          en_b, we_b;

  always #5 clk = ~clk;

  dmem_portb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_LOCK(ML)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_lock(req_lock),
    .req_wstrb0(req_wstrb0), .req_wstrb1(req_wstrb1),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .en_b(en_b), .we_b(we_b), .wstrb_b(wstrb_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(dout_b)
  );

  function automatic logic [DW-1:0] init_word(input int i);
    return (i == 5) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
  endfunction

  // Read-first memory standing in for the dmem port B.
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      dout_b <= '0;
    end else if (en_b) begin
      if (we_b) begin
        for (int b = 0; b < SW; b++)
          if (wstrb_b[b]) mem[addr_b][8*b +: 8] <= din_b[8*b +: 8];
      end else begin
        dout_b <= mem[addr_b];
      end
    end
  end

  typedef struct packed {
    logic [1:0]    vld;
    logic [DW-1:0] dat;
  } rsp_t;

  rsp_t          sb[$];
  logic [DW-1:0] exp_mem [1024];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drv(input int r, input logic v, input logic we, input logic lk,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [SW-1:0] s);
    if (r == 0) begin
      req_valid[0] = v; req_we[0] = we; req_lock[0] = lk;
      req_addr0 = a; req_wdata0 = d; req_wstrb0 = s;
    end else begin
      req_valid[1] = v; req_we[1] = we; req_lock[1] = lk;
      req_addr1 = a; req_wdata1 = d; req_wstrb1 = s;
    end
  endtask

  task automatic idle();
    drv(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
    drv(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // Inputs are already driven; check this cycle at the falling edge, then let the rising edge accept.
  task automatic step(input logic [1:0] eg, input string tag);
    logic          g, we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    rsp_t          e;
    @(negedge clk);
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    end
    g  = eg[1];
    we = g ? req_we[1] : req_we[0];
    a  = g ? req_addr1 : req_addr0;
    d  = g ? req_wdata1 : req_wdata0;
    s  = g ? req_wstrb1 : req_wstrb0;
    chk({tag, " ready"}, 64'(req_ready), 64'(eg));
    chk({tag, " en_b"}, 64'(en_b), 64'(eg != 2'b00));
    if (eg != 2'b00) begin
      chk({tag, " addr_b"}, 64'(addr_b), 64'(a));
      chk({tag, " we_b"}, 64'(we_b), 64'(we));
      chk({tag, " wstrb_b"}, 64'(wstrb_b), we ? 64'(s) : 64'd0);
      if (we) chk({tag, " din_b"}, 64'(din_b), 64'(d));
    end else begin
      chk({tag, " idle wstrb_b"}, 64'(wstrb_b), 64'd0);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " rsp_valid"}, 64'(rsp_valid), 64'(e.vld));
      chk({tag, " rsp_rdata"}, 64'(rsp_rdata), 64'(e.dat));
    end else begin
      chk({tag, " no rsp_valid"}, 64'(rsp_valid), 64'd0);
    end
    if (eg != 2'b00 && !rst) begin
      if (we) begin
        for (int b = 0; b < SW; b++)
          if (s[b]) exp_mem[a][8*b +: 8] = d[8*b +: 8];
        sb.push_back('{vld: eg, dat: '0});
      end else begin
        sb.push_back('{vld: eg, dat: exp_mem[a]});
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [SW-1:0] strb0_tab [6];
  logic [SW-1:0] strb1_tab [6];
  logic [3:0]    lock_tab;

  initial begin
    strb0_tab = '{4'b0011, 4'b1111, 4'b1100, 4'b1111, 4'b0101, 4'b1111};
    strb1_tab = '{4'b1111, 4'b1111, 4'b1111, 4'b1000, 4'b1111, 4'b1111};
    lock_tab  = 4'b0111;
    for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
    rst = 1'b1;
    idle();
    @(posedge clk);
    #1;

    // Requests during reset must not be granted.
    drv(0, 1'b1, 1'b0, 1'b0, 10'h001, '0, '0);
    drv(1, 1'b1, 1'b0, 1'b0, 10'h002, '0, '0);
    step(2'b00, "in_reset0");
    step(2'b00, "in_reset1");
    rst = 1'b0;
    idle();
    step(2'b00, "after_reset");

    // Single read by requester 1.
    drv(1, 1'b1, 1'b0, 1'b0, 10'h005, '0, 4'hF);
    step(2'b10, "single_read");
    idle();
    step(2'b00, "single_rsp");

    // Contention: both write every cycle, grants alternate starting with 0.
    for (int i = 0; i < 6; i++) begin
      drv(0, 1'b1, 1'b1, 1'b0, 10'(16 + i), 32'h11223300 + 32'(i), strb0_tab[i]);
      drv(1, 1'b1, 1'b1, 1'b0, 10'(32 + i), 32'h55667700 + 32'(i), strb1_tab[i]);
      step((i % 2 == 0) ? 2'b01 : 2'b10, $sformatf("contend%0d", i));
    end
    idle();
    step(2'b00, "contend_drain");
    drv(0, 1'b1, 1'b0, 1'b0, 10'h010, '0, '0); step(2'b01, "rb_010");
    drv(0, 1'b1, 1'b0, 1'b0, 10'h012, '0, '0); step(2'b01, "rb_012");
    drv(0, 1'b1, 1'b0, 1'b0, 10'h014, '0, '0); step(2'b01, "rb_014");
    drv(0, 1'b1, 1'b0, 1'b0, 10'h023, '0, '0); step(2'b01, "rb_023");
    drv(0, 1'b1, 1'b0, 1'b0, 10'h011, '0, '0); step(2'b01, "rb_011");
    idle();
    step(2'b00, "rb_drain");

    // Lock burst by requester 1 while requester 0 waits.
    for (int i = 0; i < 4; i++) begin
      drv(0, 1'b1, 1'b0, 1'b0, 10'h011, '0, '0);
      drv(1, 1'b1, 1'b0, lock_tab[i], 10'(32 + i), '0, '0);
      step(2'b10, $sformatf("burst%0d", i));
    end
    drv(1, 1'b1, 1'b0, 1'b0, 10'h024, '0, '0);
    step(2'b01, "burst_release");
    idle();
    step(2'b00, "burst_drain");

    // Fairness: requester 0 locks continuously, requester 1 gets every fifth beat.
    drv(1, 1'b1, 1'b0, 1'b0, 10'h005, '0, '0);
    step(2'b10, "fair_prime");
    for (int i = 0; i < 10; i++) begin
      drv(0, 1'b1, 1'b1, 1'b1, 10'(48 + i), 32'hC0DE0000 + 32'(i), 4'hF);
      drv(1, 1'b1, 1'b0, 1'b0, 10'h005, '0, '0);
      step((i == 4 || i == 9) ? 2'b10 : 2'b01, $sformatf("fair%0d", i));
    end

    // Lock held across idle cycles of the owner.
    for (int i = 0; i < 3; i++) begin
      drv(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
      drv(1, 1'b1, 1'b0, 1'b0, 10'h005, '0, '0);
      step(2'b00, $sformatf("lock_idle%0d", i));
    end
    drv(0, 1'b1, 1'b0, 1'b0, 10'h030, '0, '0);
    step(2'b01, "lock_unlock");
    drv(0, 1'b1, 1'b0, 1'b0, 10'h031, '0, '0);
    step(2'b10, "arb_again");
    idle();
    step(2'b00, "idle_drain");

    // Reset right after a locked read accept.
    drv(0, 1'b1, 1'b0, 1'b1, 10'h005, '0, '0);
    step(2'b01, "lock_before_rst");
    rst = 1'b1;
    drv(1, 1'b1, 1'b0, 1'b0, 10'h013, '0, '0);
    step(2'b00, "mid_rst");
    rst = 1'b0;
    drv(0, 1'b1, 1'b0, 1'b0, 10'h012, '0, '0);
    step(2'b01, "tie_after_rst");
    step(2'b10, "alt_after_rst");
    idle();
    step(2'b00, "final_drain");
    step(2'b00, "final_quiet");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
